// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// and the byte count of each access size.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Illegal sizes report 4 bytes; the error path rejects them regardless.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load formatter: takes 4 little-endian bytes and returns the
// byte/half/word result, sign- or zero-extended to 32 bits.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & raw[7]}},  raw[7:0]};
            SZ_HALF: data = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory; response valid WAIT_CYCLES edges after
// acceptance, one request in flight, response held stable until rsp_ready.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    logic [7:0] mem [DEPTH_BYTES];

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [2:0]        nbytes;
    logic [ADDR_W:0]   last_addr;
    logic              size_err;
    logic              err;
    logic              commit;
    logic [IDX_W-1:0]  idx [4];
    logic [31:0]       raw;
    logic [31:0]       ld_data;

    assign nbytes    = bytes_of(lat_size);
    // One extra bit so an access running past the top of the address space
    // cannot wrap back into range.
    assign last_addr = {1'b0, lat_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    assign err       = size_err | (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
    assign commit    = (state == ST_ACCESS) && (cnt == 4'(WAIT_CYCLES - 1));

    always_comb begin
        case (lat_size)
            SZ_BYTE: size_err = 1'b0;
            SZ_HALF: size_err = lat_addr[0];
            SZ_WORD: size_err = |lat_addr[1:0];
            default: size_err = 1'b1;
        endcase
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < 4; i++) begin
            idx[i]         = IDX_W'(lat_addr + ADDR_W'(i));
            raw[8*i +: 8]  = mem[idx[i]];
        end
    end

    dmem_load_ext u_load_ext (
        .raw         (raw),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .data        (ld_data)
    );

    // Storage is not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && commit && lat_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < nbytes) begin
                    mem[idx[i]] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            lat_we       <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        cnt          <= 4'd0;
                        req_ready    <= 1'b0;
                        state        <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (commit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || lat_we) ? 32'd0 : ld_data;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with a single wait state, one with three.
module tb_dmem_ctrl;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [10:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_v [2] = '{1'b0, 1'b0};
    exp_t sbq [2][$];
    vec_t tbl [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.ADDR_W(11), .DEPTH_BYTES(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.ADDR_W(11), .DEPTH_BYTES(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: latency on the rising response, data on the handshake.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rsp_valid[s]) begin
                chk($sformatf("no_overlap[%0d]", s), {31'd0, req_ready[s]}, 32'd0);
            end
            if (rsp_valid[s] && !prev_v[s] && sbq[s].size() > 0) begin
                chk($sformatf("latency[%0d]", s), cyc - sbq[s][0].acc, (s == 0) ? 1 : 3);
            end
            if (rsp_valid[s] && rsp_ready[s]) begin
                if (sbq[s].size() == 0) begin
                    chk($sformatf("unexpected_rsp[%0d]", s), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq[s].pop_front();
                    chk($sformatf("rdata[%0d] acc@%0d", s, e.acc), rsp_rdata[s], e.rdata);
                    chk($sformatf("err[%0d] acc@%0d", s, e.acc), {31'd0, rsp_err[s]}, {31'd0, e.err});
                end
            end
            prev_v[s] = rsp_valid[s];
        end
    end

    task automatic issue(input int s, input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[s]) begin
            chk($sformatf("req_ready_timeout[%0d]", s), 32'd0, 32'd1);
            return;
        end
        req_we[s]       = v.we;
        req_size[s]     = v.size;
        req_unsigned[s] = v.uns;
        req_addr[s]     = v.addr;
        req_wdata[s]    = v.wdata;
        req_valid[s]    = 1'b1;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        e.rdata = v.rdata;
        e.err   = v.err;
        e.acc   = cyc;
        sbq[s].push_back(e);
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (sbq[s].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq[s].size() != 0) begin
            chk($sformatf("rsp_timeout[%0d]", s), sbq[s].size(), 32'd0);
            sbq[s].delete();
        end
    endtask

    task automatic do_req(input int s, input vec_t v);
        issue(s, v);
        drain(s);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [10:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n;

        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 0; req_we[s] = 0; req_size[s] = 0; req_unsigned[s] = 0;
            req_addr[s] = 0; req_wdata[s] = 0; rsp_ready[s] = 1;
        end

        //            we    size   u     addr     wdata         rdata         err
        tbl.push_back(mk(1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h00000000, 0));
        tbl.push_back(mk(0, 2'b10, 0, 11'h010, 32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 2'b00, 0, 11'h013, 32'h0,        32'hFFFFFFDE, 0));
        tbl.push_back(mk(0, 2'b00, 1, 11'h013, 32'h0,        32'h000000DE, 0));
        tbl.push_back(mk(0, 2'b01, 0, 11'h012, 32'h0,        32'hFFFFDEAD, 0));
        tbl.push_back(mk(0, 2'b01, 1, 11'h010, 32'h0,        32'h0000BEEF, 0));
        tbl.push_back(mk(1, 2'b00, 0, 11'h011, 32'hAAAAAA7F, 32'h00000000, 0));
        tbl.push_back(mk(1, 2'b01, 0, 11'h012, 32'hBBBB1234, 32'h00000000, 0));
        tbl.push_back(mk(0, 2'b10, 1, 11'h010, 32'h0,        32'h12347FEF, 0));
        tbl.push_back(mk(1, 2'b10, 0, 11'h012, 32'hFFFFFFFF, 32'h00000000, 1));
        tbl.push_back(mk(0, 2'b10, 0, 11'h010, 32'h0,        32'h12347FEF, 0));
        tbl.push_back(mk(0, 2'b01, 0, 11'h011, 32'h0,        32'h00000000, 1));
        tbl.push_back(mk(0, 2'b10, 0, 11'h3FE, 32'h0,        32'h00000000, 1));
        tbl.push_back(mk(0, 2'b11, 0, 11'h010, 32'h0,        32'h00000000, 1));
        tbl.push_back(mk(1, 2'b11, 0, 11'h010, 32'h0,        32'h00000000, 1));
        tbl.push_back(mk(0, 2'b10, 0, 11'h010, 32'h0,        32'h12347FEF, 0));
        tbl.push_back(mk(1, 2'b01, 0, 11'h3FE, 32'h00008001, 32'h00000000, 0));
        tbl.push_back(mk(0, 2'b01, 0, 11'h3FE, 32'h0,        32'hFFFF8001, 0));
        tbl.push_back(mk(0, 2'b00, 1, 11'h3FF, 32'h0,        32'h00000080, 0));
        tbl.push_back(mk(0, 2'b00, 0, 11'h3FF, 32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 2'b00, 0, 11'h400, 32'h0,        32'h00000000, 1));
        tbl.push_back(mk(1, 2'b00, 0, 11'h7FF, 32'h000000FF, 32'h00000000, 1));

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_req_ready[%0d]", s), {31'd0, req_ready[s]}, 32'd0);
            chk($sformatf("rst_rsp_valid[%0d]", s), {31'd0, rsp_valid[s]}, 32'd0);
            chk($sformatf("rst_rsp_rdata[%0d]", s), rsp_rdata[s], 32'd0);
            chk($sformatf("rst_rsp_err[%0d]", s), {31'd0, rsp_err[s]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, req_ready[0]}, 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(0, tbl[i]);
        end

        // Back-to-back store/load pairs with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            issue(0, mk(1, 2'b10, 0, 11'(11'h100 + 4 * i), d, 32'h0, 0));
            issue(0, mk(0, 2'b10, 0, 11'(11'h100 + 4 * i), 32'h0, d, 0));
        end
        drain(0);

        // Three wait states: latency, then backpressure hold.
        do_req(1, mk(1, 2'b10, 0, 11'h020, 32'h00000000, 32'h0, 0));
        do_req(1, mk(1, 2'b10, 0, 11'h024, 32'h55AA1234, 32'h0, 0));
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        issue(1, mk(0, 2'b10, 0, 11'h024, 32'h0, 32'h55AA1234, 0));
        n = 0;
        while (!rsp_valid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", {31'd0, rsp_valid[1]}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid[1]}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata[1], 32'h55AA1234);
            chk("bp_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready[1]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready_return", {31'd0, req_ready[1]}, 32'd1);
        chk("bp_valid_clear", {31'd0, rsp_valid[1]}, 32'd0);
        drain(1);

        // Reset one edge after accepting a store: the store must be dropped.
        issue(1, mk(1, 2'b10, 0, 11'h020, 32'hCAFEF00D, 32'h0, 0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq[1].delete();
        chk("midrst_req_ready", {31'd0, req_ready[1]}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("midrst_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
        do_req(1, mk(0, 2'b10, 0, 11'h020, 32'h0, 32'h00000000, 0));
        do_req(1, mk(0, 2'b10, 0, 11'h024, 32'h0, 32'h55AA1234, 0));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, byte-addressed, little-endian data memory with a valid/ready request channel and a valid/ready response channel.
- Serves MIPS loads (lb/lbu/lh/lhu/lw) and stores (sb/sh/sw) with sign/zero extension, alignment checking and range checking.
- Models a configurable number of wait states.
- Sits between the CPU load/store stage and the memory; the CPU stalls while req_ready or rsp_valid is low.

Parameters:
- ADDR_W, 11, byte-address width of req_addr.
- DEPTH_BYTES, 1024, number of storage bytes; must be at most 2**ADDR_W and a multiple of 4.
- WAIT_CYCLES, 1, clock edges from request acceptance to response-valid; must be 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range, or illegal size.

Behaviour:
- Reset and clocking
  - One clock, clk. Reset is synchronous, active-low, on rst_n.
  - While rst_n = 0 at an edge: state goes to IDLE; req_ready=0 during reset and 1 after; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
  - Memory contents are not reset.
- States: IDLE, ACCESS, RESP.
- IDLE
  - req_ready=1.
  - On an edge with req_valid=1: latch we/size/unsigned/addr/wdata, set counter=0, go to ACCESS.
- ACCESS
  - req_ready=0.
  - The counter increments each edge.
  - On the edge where counter == WAIT_CYCLES-1:
    - Perform the access.
    - Register rsp_rdata and rsp_err.
    - Go to RESP.
  - Consequence: rsp_valid rises exactly WAIT_CYCLES edges after the acceptance edge.
- RESP
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until handshake.
  - On an edge with rsp_ready=1: go to IDLE and clear rsp_valid.
  - Next acceptance is possible one edge later, so there is no overlap between requests.
- Error check, evaluated on the latched request:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr + bytes - 1 >= DEPTH_BYTES).
  - The sum is computed ADDR_W+1 bits wide so it cannot wrap.
  - On err: no memory byte is written, rsp_rdata=0, rsp_err=1, same latency as a normal access.
- Stores: write bytes addr..addr+n-1 from wdata[8n-1:0], with the lowest byte at the lowest address; rsp_rdata=0.
- Loads:
  - Read bytes are assembled little-endian.
  - Byte/half results are extended to 32 bits: sign from bit 7/15 when req_unsigned=0, zero otherwise.
  - Word loads ignore req_unsigned.
- Data is sampled at commit: a load issued after a store's response sees the stored data.
- Reset mid-operation
  - A store not yet committed is dropped.
  - A response pending in RESP is discarded.
- Illegal inputs
  - req_valid with X or illegal size is reported through rsp_err and never writes.
  - Inputs outside IDLE are ignored.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding for IDLE/ACCESS/RESP;
  - function bytes_of(size).
- Sub-module dmem_load_ext: combinational; inputs 4 raw bytes, size, unsigned; output the 32-bit extended result. It is reused by the future cache.
- Storage and FSM remain in dmem_ctrl.

Test Plan:
- Store then loads (WAIT_CYCLES=1). Store word 0xDEADBEEF at 0x010, then:
  - lw 0x010 -> 0xDEADBEEF, err=0;
  - lb 0x013 -> 0xFFFFFFDE;
  - lbu 0x013 -> 0x000000DE;
  - lh 0x012 -> 0xFFFFDEAD;
  - lhu 0x010 -> 0x0000BEEF.
  - Each rsp_valid appears 1 edge after acceptance.
- Partial stores. sb 0x7F at 0x011, then sh 0x1234 at 0x012 over the word above -> lw 0x010 returns 0x12347FEF.
- Alignment and range (all expect rsp_err=1, rsp_rdata=0):
  - sw 0xFFFFFFFF at 0x012; a following lw 0x010 shows the word unchanged;
  - lh 0x011;
  - lw 0x3FE (DEPTH 1024);
  - size 11.
- Latency and backpressure (WAIT_CYCLES=3):
  - rsp_valid rises exactly 3 edges after acceptance;
  - hold rsp_ready=0 for 4 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout;
  - after rsp_ready=1, req_ready returns 1 the next cycle.
- Reset mid-access (WAIT_CYCLES=3):
  - accept sw 0xCAFEF00D at 0x020, pulse rst_n=0 one edge later -> outputs at reset values;
  - a later lw 0x020 returns the prior contents (previously written 0x00000000).
- Back-to-back requests with rsp_ready tied 1:
  - 8 alternating sw/lw pairs to incrementing word addresses;
  - every load returns its paired store data;
  - req_ready is never high while rsp_valid=1.
